// File: rtl/cmp_seq_arbiter.sv
// rtl/cmp_seq_arbiter.sv - two-port round-robin iterative magnitude comparator
// Scans operands MSB-first one CHUNK slice per cycle, stopping at the first differing slice.
module cmp_seq_arbiter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [2:0]       req_op_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [2:0]       req_op_1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_op;
    logic             r_id;
    logic             r_rr;
    logic [IW-1:0]    r_idx;

    logic             w_grant;
    logic             w_hs;
    logic             w_signed;
    logic             w_true;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [2:0]       w_op_in;
    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic             w_mismatch;
    logic             w_lt;
    logic             w_scan_end;

    always_comb begin
        w_grant = req_valid[1];
        if (req_valid == 2'b11) begin
            w_grant = r_rr;
        end
    end

    assign req_ready = (r_state == S_IDLE && req_valid != 2'b00) ? {w_grant, ~w_grant} : 2'b00;
    assign w_hs      = |req_ready;

    assign w_a_in  = w_grant ? req_a_1  : req_a_0;
    assign w_b_in  = w_grant ? req_b_1  : req_b_0;
    assign w_op_in = w_grant ? req_op_1 : req_op_0;
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign w_signed = w_op_in[2] & ~w_op_in[1];

    assign w_a_sl     = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_b_sl     = r_b[int'(r_idx) * CHUNK +: CHUNK];
    assign w_mismatch = (w_a_sl != w_b_sl);
    assign w_lt       = (w_a_sl < w_b_sl);
    assign w_scan_end = w_mismatch | (r_idx == '0);

    // Only meaningful on the final scan cycle: a mismatch there decides lt, otherwise eq.
    always_comb begin
        w_true = 1'b0;
        case (r_op)
            3'b000:         w_true = ~w_mismatch;
            3'b001:         w_true = w_mismatch;
            3'b100, 3'b110: w_true = w_mismatch & w_lt;
            3'b101, 3'b111: w_true = ~(w_mismatch & w_lt);
            default:        w_true = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_scan_end) w_state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr     <= 1'b0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_idx    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_hs) begin
                r_a   <= {w_a_in[WIDTH-1] ^ w_signed, w_a_in[WIDTH-2:0]};
                r_b   <= {w_b_in[WIDTH-1] ^ w_signed, w_b_in[WIDTH-2:0]};
                r_op  <= w_op_in;
                r_id  <= w_grant;
                r_idx <= IW'(NCHUNK - 1);
                r_rr  <= ~w_grant;
            end
            if (r_state == S_SCAN) begin
                if (w_scan_end) begin
                    r_result <= {WIDTH{w_true}};
                end else begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_cmp_seq_arbiter.sv
// tb/tb_cmp_seq_arbiter.sv - self-checking bench for cmp_seq_arbiter
module tb_cmp_seq_arbiter;
    localparam int WIDTH  = 32;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [WIDTH-1:0]  req_a_0, req_b_0, req_a_1, req_b_1;
    logic [2:0]        req_op_0, req_op_1;
    logic              rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0]  rsp_result;

    int n_checks = 0;
    int n_err    = 0;

    cmp_seq_arbiter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_op_0(req_op_0),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_op_1(req_op_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic t;
        case (op)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t ? 32'hFFFF_FFFF : 32'h0;
    endfunction

    // Cycles from handshake to rsp_valid: one per slice scanned down to the highest differing bit, plus one.
    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a ^ b;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (d[k]) return 1 + (NCHUNK - 1 - k / CHUNK) + 1;
        end
        return NCHUNK + 1;
    endfunction

    task automatic run_one(input logic id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] er, input int el,
                           input int hold);
        int          lat;
        logic [31:0] hres;
        logic        hid;
        req_a_0 = $urandom; req_b_0 = $urandom; req_op_0 = 3'($urandom);
        req_a_1 = $urandom; req_b_1 = $urandom; req_op_1 = 3'($urandom);
        if (id) begin
            req_a_1 = a; req_b_1 = b; req_op_1 = op; req_valid = 2'b10;
        end else begin
            req_a_0 = a; req_b_0 = b; req_op_0 = op; req_valid = 2'b01;
        end
        rsp_ready = (hold == 0);
        #1;
        check("req_ready_grant", 32'(req_ready), id ? 32'd2 : 32'd1);
        step();
        req_valid = 2'b00;
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            req_valid = 2'($urandom);
            req_a_0 = $urandom; req_a_1 = $urandom; req_op_0 = 3'($urandom);
            #1;
            check("req_ready_scan", 32'(req_ready), 32'd0);
            check("busy_scan", 32'(busy), 32'd1);
            step();
            lat++;
        end
        if (!rsp_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, expected at %0d", lat, el);
            req_valid = 2'b00;
            rsp_ready = 1'b1;
            return;
        end
        check("latency", 32'(lat), 32'(el));
        check("rsp_result", rsp_result, er);
        check("rsp_id", 32'(rsp_id), 32'(id));
        hres = rsp_result;
        hid  = rsp_id;
        for (int h = 0; h < hold; h++) begin
            req_valid = 2'($urandom);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", rsp_result, hres);
            check("hold_id", 32'(rsp_id), 32'(hid));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            step();
        end
        check("done_valid", 32'(rsp_valid), 32'd1);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int          grants[4];
        int          ng;
        logic [1:0]  prev;
        logic        rid;
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        vecs[0]  = '{1'b0, 32'h0000_0001, 32'h0000_0002, 3'b110, 32'hFFFF_FFFF, 9, 0};
        vecs[1]  = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 32'h0000_0000, 2, 0};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'hFFFF_FFFF, 2, 0};
        vecs[3]  = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000, 32'hFFFF_FFFF, 9, 0};
        vecs[4]  = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001, 32'h0000_0000, 9, 0};
        vecs[5]  = '{1'b0, 32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0000, 9, 0};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 32'hFFFF_FFFF, 2, 5};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0000, 2, 0};
        vecs[8]  = '{1'b1, 32'h1234_5678, 32'h1234_5679, 3'b100, 32'hFFFF_FFFF, 9, 0};
        vecs[9]  = '{1'b0, 32'h00F0_0000, 32'h00E0_0000, 3'b101, 32'hFFFF_FFFF, 4, 1};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 3'b011, 32'h0000_0000, 9, 0};

        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req_a_0 = '0; req_b_0 = '0; req_op_0 = '0;
        req_a_1 = '0; req_b_1 = '0; req_op_1 = '0;
        repeat (3) step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);

        // Both requesters continuously valid: grants must alternate starting at 0.
        req_a_0 = 32'h8000_0000; req_b_0 = 32'h0; req_op_0 = 3'b110;
        req_a_1 = 32'h8000_0000; req_b_1 = 32'h0; req_op_1 = 3'b110;
        req_valid = 2'b11; rsp_ready = 1'b1; rst = 1'b0;
        #1;
        ng = 0; prev = 2'b00;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            check("ready_not_both", 32'(req_ready == 2'b11), 32'd0);
            if (req_ready != 2'b00) begin
                check("ready_only_idle", 32'(busy), 32'd0);
                check("ready_one_cycle", 32'(prev), 32'd0);
                grants[ng] = int'(req_ready[1]);
                ng++;
            end
            prev = req_ready;
            step();
        end
        check("rr_grant_count", 32'(ng), 32'd4);
        for (int g = 0; g < ng; g++) check("rr_order", 32'(grants[g]), 32'(g % 2));
        req_valid = 2'b00;
        for (int k = 0; k < 20 && busy; k++) step();
        check("rr_drain_idle", 32'(busy), 32'd0);

        // Reset during SCAN abandons the compare and clears rr.
        req_a_0 = 32'hDEAD_BEEF; req_b_0 = 32'hDEAD_BEEF; req_op_0 = 3'b000;
        req_valid = 2'b01;
        #1;
        check("abort_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_result", rsp_result, 32'd0);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        check("abort_rr_reset", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        for (int k = 0; k < 12; k++) begin
            step();
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_one(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000, 32'hFFFF_FFFF, 9, 0);

        foreach (vecs[i])
            run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].lat, vecs[i].hold);

        for (int i = 0; i < 150; i++) begin
            rid = 1'($urandom);
            ra  = $urandom;
            case ($urandom % 4)
                0:       rb = ra;
                1:       rb = $urandom;
                2:       rb = ra ^ (32'd1 << ($urandom % 32));
                default: rb = ra ^ ($urandom & 32'h0000_00FF);
            endcase
            rop = 3'($urandom);
            run_one(rid, ra, rb, rop, model_res(ra, rb, rop), model_lat(ra, rb), int'($urandom % 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/cmp_seq_arbiter.md
Name: cmp_seq_arbiter

Overview:
Iterative magnitude-compare engine for the execute stage, shared between two requesters (port 0: branch resolver, port 1: ALU set-less-than path). It accepts one compare at a time under round-robin arbitration. It scans operands MSB-first in CHUNK-bit slices and terminates early on the first mismatching slice. It returns an all-ones/all-zeros mask result over a valid/ready response channel.

Parameters:
WIDTH, 32, operand and result width
CHUNK, 4, bits compared per scan cycle; must divide WIDTH (NCHUNK = WIDTH/CHUNK)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  2  per-requester request valid; bit i = requester i
req_ready  out  2  per-requester accept; one-hot or zero
req_a_0  in  WIDTH  operand a, requester 0
req_b_0  in  WIDTH  operand b, requester 0
req_op_0  in  3  compare op, requester 0
req_a_1  in  WIDTH  operand a, requester 1
req_b_1  in  WIDTH  operand b, requester 1
req_op_1  in  3  compare op, requester 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  index of the requester that owns the response
rsp_result  out  WIDTH  all-ones if the compare is true, else zero
busy  out  1  high when state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Op encoding: 000 EQ, 001 NE, 100 LT (signed), 101 GE (signed), 110 LTU, 111 GEU.
  - 010, 011, 01x are illegal. They complete normally with rsp_result = 0.
- Reset values: state IDLE, rr = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, busy = 0, req_ready = 00.
- FSM states: IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - Grant g: if both valid, g = rr; otherwise g = the single valid requester.
  - req_ready[g] = 1, combinational from req_valid. Requesters must not derive valid from ready.
  - On handshake, capture a, b, op and id = g. Set slice idx = NCHUNK-1. Set rr = ~g. Go to SCAN.
  - For signed ops, invert bit WIDTH-1 of both captured operands so that an unsigned scan gives the signed order.
- SCAN, one slice per cycle:
  - If slice[idx] of a != slice[idx] of b: record lt = (a_slice < b_slice) and gt = !lt. Go to DONE.
  - Else if idx == 0: record eq. Go to DONE.
  - Else idx = idx - 1.
  - req_ready = 00 and input changes are ignored.
- DONE:
  - rsp_valid = 1. rsp_result, rsp_id and rsp_valid are held stable until rsp_ready.
  - Result: EQ = eq; NE = !eq; LT/LTU = lt; GE/GEU = !lt.
  - On rsp_valid & rsp_ready, go to IDLE next cycle. The registered rsp_valid drops.
  - No new request is accepted in the DONE cycle.
- Latency, with the request handshake in cycle T:
  - Minimum: mismatch in the top slice gives rsp_valid in cycle T+2.
  - Maximum: equal operands, or a mismatch only in slice 0, gives rsp_valid in cycle T+1+NCHUNK (T+9 at defaults).
- Throughput: at most one compare per (latency + 1) cycles. rr guarantees that each requester, while continuously valid, is served within 2 grants.
- Reset mid-operation: rst during SCAN or DONE abandons the operation. No response is emitted. All state returns to reset values on the next edge.
- Simultaneous events:
  - rst has priority over all handshakes.
  - A rsp handshake and new request valids in the same cycle: the request waits for IDLE.

Test Plan:
1. Requester 0, LTU, a=0x00000001, b=0x00000002, handshake at T -> rsp_valid rises at T+9, rsp_result=0xFFFFFFFF, rsp_id=0, busy=1 from T+1 until the rsp handshake.
2. Requester 1, GE, a=0x80000000, b=0x7FFFFFFF -> rsp_valid at T+2, rsp_result=0x00000000, rsp_id=1. The same operands with GEU -> 0xFFFFFFFF at T+2.
3. Both requesters held valid from reset release, rsp_ready=1 -> grant order 0, 1, 0, 1; req_ready never 11; each req_ready pulse lasts one cycle and only in IDLE.
4. EQ with a=b=0xDEADBEEF -> 0xFFFFFFFF at T+9. NE with the same operands -> 0. Illegal op 3'b010 -> 0 with a normal response.
5. rsp_ready held low for 5 cycles in DONE -> rsp_valid, rsp_result and rsp_id stable across all 5 cycles; req_ready=00; busy=1. On release, the handshake completes and IDLE follows next cycle.
6. rst asserted for 1 cycle during SCAN (cycle T+3 of a full-length compare) -> next cycle busy=0, rsp_valid=0, rr=0; no response for that request. A fresh request completes normally.
